// File: rtl/quad_emitter.sv
// Quadrature encoder emitter: turns single-step requests into a Gray-coded A/B pair
// with a minimum dwell between edges. Optional QUAD_EMITTER_POSITION_EN adds a position counter.
module quad_emitter #(
    parameter int unsigned DWELL_CYCLES = 32000,
    parameter int unsigned MAX_PENDING  = 7
) (
    input  logic        clk32mhz,
    input  logic        reset,
    input  logic        step_valid,
    input  logic        step_dir,
    output logic        step_ready,
    output logic        quad_a,
    output logic        quad_b,
    output logic        busy,
    output logic [7:0]  pending
`ifdef QUAD_EMITTER_POSITION_EN
    ,
    output logic [15:0] position
`endif
);

    localparam int unsigned DwellW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam logic [DwellW-1:0] DwellReload = DwellW'(DWELL_CYCLES - 1);
    localparam logic signed [7:0] PendMax = 8'(MAX_PENDING);

    logic signed [7:0]  pending_q, pending_d;
    logic [DwellW-1:0]  dwell_q, dwell_d;
    logic               quad_a_q, quad_a_d;
    logic               quad_b_q, quad_b_d;
    logic               busy_q, busy_d;
    logic               accept, emit, emit_cw;
    logic signed [7:0]  req, drain;
    logic [1:0]         phase_cur, phase_nxt;

`ifdef QUAD_EMITTER_POSITION_EN
    logic [15:0] position_q, position_d;
`endif

    // Saturation is judged on the pre-update count, even when an emit drains it this cycle.
    assign step_ready = step_dir ? (pending_q < PendMax) : (pending_q > -PendMax);

    always_comb begin
        accept  = step_valid && step_ready;
        emit    = (dwell_q == '0) && (pending_q != 8'sd0);
        emit_cw = !pending_q[7];
        req     = 8'sd0;
        drain   = 8'sd0;
        if (accept) begin
            req = step_dir ? 8'sd1 : -8'sd1;
        end
        if (emit) begin
            drain = emit_cw ? 8'sd1 : -8'sd1;
        end
        pending_d = pending_q + req - drain;
        busy_d    = (pending_d != 8'sd0);

        dwell_d = dwell_q;
        if (emit) begin
            dwell_d = DwellReload;
        end else if (dwell_q != '0) begin
            dwell_d = dwell_q - 1'b1;
        end

        // Phase index 0..3 maps to {a,b} = 00,01,11,10; clockwise counts up.
        phase_cur = {quad_a_q, quad_a_q ^ quad_b_q};
        phase_nxt = phase_cur;
        if (emit) begin
            phase_nxt = emit_cw ? phase_cur + 2'd1 : phase_cur - 2'd1;
        end
        quad_a_d = phase_nxt[1];
        quad_b_d = phase_nxt[1] ^ phase_nxt[0];

`ifdef QUAD_EMITTER_POSITION_EN
        position_d = position_q;
        if (emit) begin
            position_d = emit_cw ? position_q + 16'd1 : position_q - 16'd1;
        end
`endif
    end

    always_ff @(posedge clk32mhz or negedge reset) begin
        if (!reset) begin
            pending_q <= 8'sd0;
            dwell_q   <= '0;
            quad_a_q  <= 1'b0;
            quad_b_q  <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            pending_q <= pending_d;
            dwell_q   <= dwell_d;
            quad_a_q  <= quad_a_d;
            quad_b_q  <= quad_b_d;
            busy_q    <= busy_d;
        end
    end

`ifdef QUAD_EMITTER_POSITION_EN
    always_ff @(posedge clk32mhz or negedge reset) begin
        if (!reset) begin
            position_q <= 16'd0;
        end else begin
            position_q <= position_d;
        end
    end

    assign position = position_q;
`endif

    assign quad_a  = quad_a_q;
    assign quad_b  = quad_b_q;
    assign busy    = busy_q;
    assign pending = pending_q;

endmodule

// File: tb/tb_quad_emitter.sv
// Self-checking bench for quad_emitter: vector table, directed corner sequences and
// randomized traffic against a time-stamp based reference model.
module tb_quad_emitter;

    localparam int DW   = 4;
    localparam int MAXP = 7;

    logic       clk32mhz = 1'b0;
    logic       reset = 1'b1;
    logic       step_valid = 1'b0;
    logic       step_dir = 1'b0;
    logic       step_ready, quad_a, quad_b, busy;
    logic [7:0] pending;
`ifdef QUAD_EMITTER_POSITION_EN
    logic [15:0] position;
`endif

    int tests = 0;
    int fails = 0;

    // Reference model: net request count, integer shaft position, cycle of last edge.
    int m_pend = 0;
    int m_pos  = 0;
    int m_last = -1000;
    int m_cyc  = 0;

    quad_emitter #(
        .DWELL_CYCLES(DW),
        .MAX_PENDING (MAXP)
    ) dut (
        .clk32mhz  (clk32mhz),
        .reset     (reset),
        .step_valid(step_valid),
        .step_dir  (step_dir),
        .step_ready(step_ready),
        .quad_a    (quad_a),
        .quad_b    (quad_b),
        .busy      (busy),
        .pending   (pending)
`ifdef QUAD_EMITTER_POSITION_EN
        ,
        .position  (position)
`endif
    );

    always #5 clk32mhz = ~clk32mhz;

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    function automatic logic [1:0] gray_of(input int p);
        case (p & 3)
            0:       return 2'b00;
            1:       return 2'b01;
            2:       return 2'b11;
            default: return 2'b10;
        endcase
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_outputs();
        logic [1:0] ab;
        ab = gray_of(m_pos);
        chk("quad_a", int'(quad_a), int'(ab[1]));
        chk("quad_b", int'(quad_b), int'(ab[0]));
        chk("pending", int'($signed(pending)), m_pend);
        chk("busy", int'(busy), int'(m_pend != 0));
`ifdef QUAD_EMITTER_POSITION_EN
        chk("position", int'(position), m_pos & 32'hFFFF);
`endif
    endtask

    // Called at posedge+1; returns at the next posedge+1 after checking outputs.
    task automatic tick(input logic v, input logic d, output logic rdy);
        bit m_rdy, acc, emit;
        int sgn;
        step_valid = v;
        step_dir   = d;
        #1;
        rdy   = step_ready;
        m_rdy = d ? (m_pend < MAXP) : (m_pend > -MAXP);
        chk("step_ready", int'(step_ready), int'(m_rdy));
        acc  = v && m_rdy;
        emit = (m_pend != 0) && (m_cyc - m_last >= DW);
        if (emit) begin
            sgn    = (m_pend > 0) ? 1 : -1;
            m_pos  = m_pos + sgn;
            m_pend = m_pend - sgn;
            m_last = m_cyc;
        end
        if (acc) m_pend = m_pend + (d ? 1 : -1);
        m_cyc++;
        @(posedge clk32mhz);
        #1;
        check_outputs();
    endtask

    task automatic do_reset();
        step_valid = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        chk("rst_quad_a", int'(quad_a), 0);
        chk("rst_quad_b", int'(quad_b), 0);
        chk("rst_pending", int'(pending), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_ready", int'(step_ready), 1);
`ifdef QUAD_EMITTER_POSITION_EN
        chk("rst_position", int'(position), 0);
`endif
        @(posedge clk32mhz);
        #1;
        reset  = 1'b1;
        m_cyc++;
        m_pend = 0;
        m_pos  = 0;
        m_last = m_cyc - 1000;
    endtask

    typedef struct {
        logic       v;
        logic       d;
        logic       rdy;
        logic [1:0] ab;
        int         pend;
        logic       bsy;
    } vec_t;

    vec_t vecs[11];

    initial begin
        logic r;
        logic [1:0] prev_ab, cur_ab;
        logic [1:0] ccw_seq[4];
        int nedge, last_edge;

        // Three clockwise requests back-to-back, edges at +2, +6, +10.
        vecs[0]  = '{1'b1, 1'b1, 1'b1, 2'b00, 1, 1'b1};
        vecs[1]  = '{1'b1, 1'b1, 1'b1, 2'b01, 1, 1'b1};
        vecs[2]  = '{1'b1, 1'b1, 1'b1, 2'b01, 2, 1'b1};
        vecs[3]  = '{1'b0, 1'b1, 1'b1, 2'b01, 2, 1'b1};
        vecs[4]  = '{1'b0, 1'b1, 1'b1, 2'b01, 2, 1'b1};
        vecs[5]  = '{1'b0, 1'b1, 1'b1, 2'b11, 1, 1'b1};
        vecs[6]  = '{1'b0, 1'b1, 1'b1, 2'b11, 1, 1'b1};
        vecs[7]  = '{1'b0, 1'b1, 1'b1, 2'b11, 1, 1'b1};
        vecs[8]  = '{1'b0, 1'b1, 1'b1, 2'b11, 1, 1'b1};
        vecs[9]  = '{1'b0, 1'b1, 1'b1, 2'b10, 0, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 1'b1, 2'b10, 0, 1'b0};

        ccw_seq[0] = 2'b10;
        ccw_seq[1] = 2'b11;
        ccw_seq[2] = 2'b01;
        ccw_seq[3] = 2'b00;

        @(posedge clk32mhz);
        #1;
        do_reset();

        // Idle after reset.
        for (int i = 0; i < 20; i++) begin
            tick(1'b0, 1'($urandom_range(0, 1)), r);
            chk("idle_ready", int'(r), 1);
            chk("idle_ab", int'({quad_a, quad_b}), 0);
        end

        for (int i = 0; i < 11; i++) begin
            tick(vecs[i].v, vecs[i].d, r);
            chk("tbl_ready", int'(r), int'(vecs[i].rdy));
            chk("tbl_ab", int'({quad_a, quad_b}), int'(vecs[i].ab));
            chk("tbl_pending", int'($signed(pending)), vecs[i].pend);
            chk("tbl_busy", int'(busy), int'(vecs[i].bsy));
        end

        // Clockwise then counter-clockwise before the first emit.
        do_reset();
        tick(1'b1, 1'b1, r);
        tick(1'b1, 1'b0, r);
        chk("cancel_ab_first", int'({quad_a, quad_b}), 1);
        chk("cancel_pending", int'($signed(pending)), -1);
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, r);
        chk("cancel_ab_back", int'({quad_a, quad_b}), 0);
        chk("cancel_idle", int'(busy), 0);

        // Four counter-clockwise steps: Gray order, one-bit change, exact spacing.
        do_reset();
        nedge     = 0;
        last_edge = 0;
        prev_ab   = 2'b00;
        for (int i = 0; i < 30; i++) begin
            tick(i < 4, 1'b0, r);
            cur_ab = {quad_a, quad_b};
            if (cur_ab != prev_ab) begin
                chk("gray_onehot", $countones(cur_ab ^ prev_ab), 1);
                if (nedge < 4) chk("ccw_seq", int'(cur_ab), int'(ccw_seq[nedge]));
                if (nedge > 0) chk("edge_spacing", i - last_edge, DW);
                last_edge = i;
                nedge++;
            end
            prev_ab = cur_ab;
        end
        chk("ccw_edges", nedge, 4);

        // Saturation at +MAX_PENDING; opposite direction still accepted.
        do_reset();
        for (int i = 0; i < 40; i++) begin
            if (m_pend == MAXP) break;
            tick(1'b1, 1'b1, r);
        end
        chk("sat_pending", int'($signed(pending)), MAXP);
        tick(1'b1, 1'b1, r);
        chk("sat_cw_ready", int'(r), 0);
        tick(1'b1, 1'b0, r);
        chk("sat_ccw_ready", int'(r), 1);

        // Reset with pending=+5 and {a,b}=11.
        do_reset();
        for (int i = 0; i < 40; i++) begin
            if (m_pend == 5 && (m_pos & 3) == 2) break;
            tick(m_pend < 5, 1'b1, r);
        end
        chk("pre_rst_pending", int'($signed(pending)), 5);
        chk("pre_rst_ab", int'({quad_a, quad_b}), 3);
        do_reset();

        // Randomized traffic against the model.
        for (int i = 0; i < 500; i++) begin
            logic v, d;
            v = ($urandom_range(0, 2) != 0);
            d = (i < 250) ? ($urandom_range(0, 3) != 0) : 1'($urandom_range(0, 1));
            if (i % 97 == 50) begin
                for (int k = 0; k < 12; k++) tick(1'b0, d, r);
            end
            tick(v, d, r);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
